// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / MUL-DIV stall and branch-flush control.
// Stall counter built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_use_hilo,
  input  logic                  ex_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                  ex_branch_tk,
  input  logic                  md_start,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  // BUSY runs cnt down to 0, so load two less than the total latency
  localparam logic [7:0] CNT_LOAD =
    (MD_LATENCY > 1) ? 8'(MD_LATENCY - 2) : 8'd0;

  md_state_t  state;
  md_state_t  state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;

  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic mdh;
  logic hazard;
  logic stall;
  logic flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (md_start) begin
          if (MD_LATENCY == 1) begin
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (cnt == 8'd0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      DONE: begin
        md_busy  = 1'b1;
        md_done  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // $0 is hard-wired, so a load targeting it never creates a hazard
  assign rs_hit = id_use_rs & (id_rs_addr == ex_rd_addr);
  assign rt_hit = id_use_rt & (id_rt_addr == ex_rd_addr);
  assign lu     = ex_mem_read & (ex_rd_addr != '0) & (rs_hit | rt_hit);
  assign mdh    = id_use_hilo & md_busy;
  assign hazard = lu | mdh;

  always_comb begin
    flush = 1'b0;
    stall = 1'b0;
    unique case (1'b1)
      ex_branch_tk: begin
        flush = 1'b1;
      end
      (!ex_branch_tk && hazard): begin
        stall = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_en      = ~stall;
  assign ifid_en    = ~stall;
  assign ifid_flush = flush;
  assign idex_flush = flush | stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall && !(&stall_q)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl.
// Expected counter values depend on HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

  localparam int RN = 0;
  localparam int ST = 1;
  localparam int FL = 2;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       uh;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ms;
    logic [1:0] kind;
    logic       busy;
    logic       done;
  } row_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_use_hilo;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_branch_tk;
  logic        md_start;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_count;

  out_t obs;
  out_t sb[$];
  int   sc;
  int   total;
  int   passed;

  hazard_stall_ctrl #(
    .ADDR_WIDTH(5),
    .MD_LATENCY(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_use_hilo(id_use_hilo),
    .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr),
    .ex_branch_tk(ex_branch_tk),
    .md_start(md_start),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .md_busy(md_busy),
    .md_done(md_done),
    .stall_count(stall_count)
  );

  assign obs = {pc_en, ifid_en, ifid_flush, idex_flush,
                md_busy, md_done, stall_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t r(bit rst, int rs, int rt, bit urs, bit urt,
                             bit uh, bit mr, int rd, bit br, bit ms,
                             int kind, bit busy, bit done);
    row_t x;
    x.rst  = rst;
    x.rs   = 5'(rs);
    x.rt   = 5'(rt);
    x.urs  = urs;
    x.urt  = urt;
    x.uh   = uh;
    x.mr   = mr;
    x.rd   = 5'(rd);
    x.br   = br;
    x.ms   = ms;
    x.kind = 2'(kind);
    x.busy = busy;
    x.done = done;
    return x;
  endfunction

  function automatic out_t mk(int kind, bit busy, bit done, int c);
    out_t o;
    o.pc_en      = (kind != ST);
    o.ifid_en    = (kind != ST);
    o.ifid_flush = (kind == FL);
    o.idex_flush = (kind != RN);
    o.md_busy    = busy;
    o.md_done    = done;
`ifdef HAZARD_PERF_CNT_EN
    o.cnt = (c > 65535) ? 16'hFFFF : 16'(c);
`else
    o.cnt = 16'd0;
`endif
    return o;
  endfunction

  task automatic drive_push(input row_t x);
    reset        = x.rst;
    id_rs_addr   = x.rs;
    id_rt_addr   = x.rt;
    id_use_rs    = x.urs;
    id_use_rt    = x.urt;
    id_use_hilo  = x.uh;
    ex_mem_read  = x.mr;
    ex_rd_addr   = x.rd;
    ex_branch_tk = x.br;
    md_start     = x.ms;
    sb.push_back(mk(int'(x.kind), x.busy, x.done, sc));
    if (x.rst) sc = 0;
    else if (int'(x.kind) == ST) sc++;
  endtask

  task automatic test_reset();
    row_t rq[$];
    out_t e;
    @(posedge clk);
    #1;
    rq.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    row_t rq[$];
    out_t e;
    rq.push_back(r(0, 5, 0, 1, 0, 0, 1, 5, 0, 0, ST, 0, 0));
    rq.push_back(r(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_hazard();
    row_t rq[$];
    out_t e;
    rq.push_back(r(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 3, 5, 1, 0, 0, 1, 5, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 5, 0, 1, 0, 0, 0, 5, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 6, 7, 1, 1, 0, 1, 5, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 2, 5, 0, 1, 0, 1, 5, 0, 0, ST, 0, 0));
    rq.push_back(r(0, 2, 5, 0, 1, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 31, 0, 1, 0, 0, 1, 31, 0, 0, ST, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL no_hazard[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_muldiv();
    row_t rq[$];
    out_t e;
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, ST, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ST, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, ST, 1, 1));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL muldiv[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    row_t rq[$];
    out_t e;
    rq.push_back(r(0, 5, 0, 1, 0, 0, 1, 5, 1, 0, FL, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FL, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ST, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ST, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ST, 1, 1));
    rq.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL branch[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_busy();
    row_t rq[$];
    out_t e;
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 1, 0));
    rq.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 1, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    rq.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0));
    foreach (rq[i]) begin
      drive_push(rq[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL reset_busy[%0d] got=%h exp=%h", i, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation();
    row_t st_row;
    row_t rn_row;
    out_t e;
    st_row = r(0, 9, 0, 1, 0, 0, 1, 9, 0, 0, ST, 0, 0);
    rn_row = r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RN, 0, 0);
    for (int n = 0; n < 65536 + 5 + 2; n++) begin
      drive_push((n < 65541 || n == 65542) ? st_row : rn_row);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) $display("FAIL saturation[%0d] got=%h exp=%h", n, obs, e);
      else passed++;
      @(posedge clk);
      #1;
    end
    drive_push(rn_row);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (obs !== e) $display("FAIL sat_final got=%h exp=%h", obs, e);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sc           = 0;
    total        = 0;
    passed       = 0;
    reset        = 1'b1;
    id_rs_addr   = '0;
    id_rt_addr   = '0;
    id_use_rs    = 1'b0;
    id_use_rt    = 1'b0;
    id_use_hilo  = 1'b0;
    ex_mem_read  = 1'b0;
    ex_rd_addr   = '0;
    ex_branch_tk = 1'b0;
    md_start     = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_muldiv();
    test_branch();
    test_reset_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
